// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared widths, word type and opcode constants for adder_subtractor_64
package addsub_pkg;
  localparam int ADDSUB_W  = 64;
  localparam int CLA_GROUP = 4;

  typedef logic [ADDSUB_W-1:0] word_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/adder_subtractor_64_cla_group4.sv
// rtl/adder_subtractor_64_cla_group4.sv - 4-bit carry-lookahead group with group propagate/generate
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:1] c;

  always_comb begin
    p = a ^ b;
    g = a & b;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    cout = gg | (pg & cin);
    s    = p ^ {c[3], c[2], c[1], cin};
  end
endmodule

// File: rtl/adder_subtractor_64.sv
// rtl/adder_subtractor_64.sv - registered add/sub with accumulate; flag outputs under ADDSUB_FLAGS_EN
module adder_subtractor_64
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic             sub,
  input  logic             acc,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
`endif
);
  localparam int NGRP = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] sum;
  logic [NGRP:0]    carry;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_g;

  assign op_a     = acc ? out_q : a;
  assign b_x      = b ^ {WIDTH{sub == OP_SUB}};
  assign carry[0] = sub;

  // Groups ripple: each group's carry-out feeds the next group's carry-in
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_cla
    cla_group4 u_grp (
      .a    (op_a[CLA_GROUP*gi +: CLA_GROUP]),
      .b    (b_x[CLA_GROUP*gi +: CLA_GROUP]),
      .cin  (carry[gi]),
      .s    (sum[CLA_GROUP*gi +: CLA_GROUP]),
      .cout (carry[gi+1]),
      .pg   (grp_p[gi]),
      .gg   (grp_g[gi])
    );
  end

  logic unused_grp_pg;
  assign unused_grp_pg = ^{grp_p, grp_g};

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (clr) begin
      out_d = '0;
    end else if (in_valid) begin
      out_d       = sum;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef ADDSUB_FLAGS_EN
  logic carry_out_q, carry_out_d;
  logic overflow_q, overflow_d;
  logic zero_q, zero_d;
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
  assign msb_cin = op_a[WIDTH-1] ^ b_x[WIDTH-1] ^ sum[WIDTH-1];

  always_comb begin
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    if (clr) begin
      carry_out_d = 1'b0;
      overflow_d  = 1'b0;
      zero_d      = 1'b0;
    end else if (in_valid) begin
      carry_out_d = carry[NGRP];
      overflow_d  = carry[NGRP] ^ msb_cin;
      zero_d      = (sum == '0);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
`else
  logic unused_carry_msb;
  assign unused_carry_msb = carry[NGRP];
`endif
endmodule

// File: tb/tb_adder_subtractor_64.sv
// tb/tb_adder_subtractor_64.sv - vector table plus scoreboarded random regression for adder_subtractor_64
module tb_adder_subtractor_64;
  import addsub_pkg::*;

  typedef struct {
    logic [63:0] out;
    logic        v;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  typedef struct {
    logic        iv;
    logic        s;
    logic        ac;
    logic        cl;
    logic [63:0] a;
    logic [63:0] b;
    exp_t        e;
  } vec_t;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        in_valid = 1'b0, sub = 1'b0, acc = 1'b0, clr = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic [63:0] out;
  logic        out_valid;
`ifdef ADDSUB_FLAGS_EN
  logic        carry_out, overflow, zero;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t model_st;

  always #5 CLK = ~CLK;

  adder_subtractor_64 dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .sub       (sub),
    .acc       (acc),
    .clr       (clr),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid)
`ifdef ADDSUB_FLAGS_EN
    ,
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
`endif
  );

  function automatic exp_t model(input logic iv, s, ac, cl, input logic [63:0] av, bv, input exp_t prev);
    exp_t        n;
    logic [63:0] opa;
    logic [63:0] bx;
    logic [64:0] full;
    n = prev;
    if (cl) begin
      n.out = '0; n.v = 1'b0; n.c = 1'b0; n.o = 1'b0; n.z = 1'b0;
    end else if (iv) begin
      opa  = ac ? prev.out : av;
      bx   = s ? ~bv : bv;
      full = {1'b0, opa} + {1'b0, bx} + {64'd0, s};
      n.out = full[63:0];
      n.c   = full[64];
      n.o   = (opa[63] == bx[63]) && (full[63] != opa[63]);
      n.z   = (full[63:0] == 64'd0);
      n.v   = 1'b1;
    end else begin
      n.v = 1'b0;
    end
    return n;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_dut(input string name);
    exp_t e;
    e = sb.pop_front();
    cmp({name, ".out"}, out, e.out);
    cmp({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, e.v});
`ifdef ADDSUB_FLAGS_EN
    cmp({name, ".carry_out"}, {63'd0, carry_out}, {63'd0, e.c});
    cmp({name, ".overflow"}, {63'd0, overflow}, {63'd0, e.o});
    cmp({name, ".zero"}, {63'd0, zero}, {63'd0, e.z});
`endif
  endtask

  // Drives one cycle of stimulus, queues its expectation, and checks after the edge
  task automatic step(input logic iv, s, ac, cl, input logic [63:0] av, bv, input exp_t e, input string name);
    in_valid = iv; sub = s; acc = ac; clr = cl; a = av; b = bv;
    sb.push_back(e);
    model_st = e;
    @(posedge CLK);
    #1;
    check_dut(name);
  endtask

  function automatic exp_t mk(input logic [63:0] o, input logic v, c, ov, z);
    exp_t e;
    e.out = o; e.v = v; e.c = c; e.o = ov; e.z = z;
    return e;
  endfunction

  vec_t vt[13];

  initial begin
    exp_t        e;
    logic [63:0] ra, rb;
    logic        rs, rac, rcl, riv;

    vt[0]  = '{1, OP_SUB, 0, 0, 64'd0, 64'd7, mk(64'hFFFF_FFFF_FFFF_FFF9, 1, 0, 0, 0)};
    vt[1]  = '{1, OP_ADD, 0, 0, MAXV, 64'd1, mk(MINV, 1, 0, 1, 0)};
    vt[2]  = '{0, OP_ADD, 0, 1, 64'd0, 64'd0, mk(64'd0, 0, 0, 0, 0)};
    vt[3]  = '{1, OP_ADD, 1, 0, 64'd0, 64'd10, mk(64'd10, 1, 0, 0, 0)};
    vt[4]  = '{1, OP_SUB, 1, 0, 64'd0, 64'd4, mk(64'd6, 1, 1, 0, 0)};
    vt[5]  = '{1, OP_ADD, 1, 0, 64'd0, -64'sd3, mk(64'd3, 1, 1, 0, 0)};
    vt[6]  = '{1, OP_ADD, 0, 1, 64'd9, 64'd9, mk(64'd0, 0, 0, 0, 0)};
    vt[7]  = '{0, OP_ADD, 0, 0, 64'd9, 64'd9, mk(64'd0, 0, 0, 0, 0)};
    vt[8]  = '{1, OP_SUB, 0, 0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, mk(64'd0, 1, 1, 0, 1)};
    vt[9]  = '{1, OP_SUB, 0, 0, 64'd0, MINV, mk(MINV, 1, 0, 1, 0)};
    vt[10] = '{0, OP_ADD, 0, 0, 64'd1, 64'd1, mk(MINV, 0, 0, 1, 0)};
    vt[11] = '{1, OP_ADD, 0, 0, MAXV, MAXV, mk(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0)};
    vt[12] = '{1, OP_ADD, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mk(64'd0, 1, 1, 0, 1)};

    // Reset held low with a live operation on the inputs
    Reset = 1'b0; in_valid = 1'b1; a = 64'd5; b = 64'd3; sub = OP_ADD;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      cmp($sformatf("reset_out[%0d]", i), out, 64'd0);
      cmp($sformatf("reset_valid[%0d]", i), {63'd0, out_valid}, 64'd0);
    end
    Reset = 1'b1;
    model_st = mk(64'd0, 0, 0, 0, 0);
    step(1, OP_ADD, 0, 0, 64'd5, 64'd3, mk(64'd8, 1, 0, 0, 0), "first_add");

    for (int i = 0; i < 13; i++)
      step(vt[i].iv, vt[i].s, vt[i].ac, vt[i].cl, vt[i].a, vt[i].b, vt[i].e, $sformatf("vec[%0d]", i));

    // Reset asserted mid-cycle with an accumulate in flight
    step(1, OP_ADD, 1, 0, 64'd0, 64'd42, mk(64'd42, 1, 0, 0, 0), "pre_reset_acc");
    in_valid = 1'b1; acc = 1'b1; b = 64'd100; clr = 1'b0; sub = OP_ADD;
    #3 Reset = 1'b0;
    #1;
    cmp("midreset_out", out, 64'd0);
    cmp("midreset_valid", {63'd0, out_valid}, 64'd0);
    @(posedge CLK);
    #1 Reset = 1'b1;
    model_st = mk(64'd0, 0, 0, 0, 0);
    step(1, OP_ADD, 1, 0, 64'd0, 64'd7, mk(64'd7, 1, 0, 0, 0), "post_reset_acc");

    for (int i = 0; i < 10000; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rs  = 1'($urandom);
      rac = 1'($urandom);
      riv = ($urandom_range(0, 7) != 0);
      rcl = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 5))
        0: rb = MINV;
        1: rb = MAXV;
        2: rb = ra;
        3: ra = 64'd0;
        default: ;
      endcase
      e = model(riv, rs, rac, rcl, ra, rb, model_st);
      step(riv, rs, rac, rcl, ra, rb, e, $sformatf("rand[%0d]", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_subtractor_64.md
Name: adder_subtractor_64

Overview:
- Registered 64-bit two's-complement adder/subtractor: out = a + b when sub=0, a − b when sub=1 (b inverted, sub used as carry-in).
- Optional accumulate mode: the registered result replaces operand a, giving acc ± b.
- Arithmetic core of the multiplier datapath: partial-product negation (0 − b) and result accumulation.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of 4.

Ports:
- CLK  input  1  system clock, rising edge active
- Reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operands valid this cycle; operation is captured on this edge
- sub  input  1  0 = add, 1 = subtract; also the carry-in of the adder core
- acc  input  1  1 = use registered out as operand a, ignore the a port
- clr  input  1  synchronous clear of out and out_valid
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- out  output  WIDTH  registered result
- out_valid  output  1  out holds a result produced by the last captured operation

Behaviour:
- Reset low, asynchronous: out=0, out_valid=0, and all flag registers =0. Reset release is synchronous to CLK.
- Core: sum = opA + (b XOR {WIDTH{sub}}) + sub, truncated to WIDTH bits; wrap-around is modulo 2^WIDTH.
- opA = acc ? out : a.
- Latency is 1 cycle. On a rising edge with in_valid=1: out <= sum and out_valid <= 1.
- Rising edge with in_valid=0: out holds its value; out_valid <= 0.
- Priority on an edge: clr > in_valid. With clr=1, out <= 0 and out_valid <= 0 regardless of in_valid.
- No backpressure. One new operation may be issued every cycle.
- acc=1 with in_valid=1 on consecutive cycles chains correctly: each cycle uses the previous cycle's out.
- Reset asserted mid-stream discards the in-flight operation. The first valid result after release uses out=0 as the accumulator.
- Core structure: carry-lookahead built from 4-bit CLA groups with ripple between groups. Combinational depth must close timing at the project clock.
- Corner cases:
  - Negating the minimum value (0 − 0x8000_0000_0000_0000) wraps to 0x8000_0000_0000_0000 with no error indication (see flags).
  - a − a = 0 for all a.

Optional Feature:
- Macro: ADDSUB_FLAGS_EN.
- Defined: adds three registered outputs, all updated on the same edge as out and all cleared by clr and Reset:
  - carry_out (1 bit): raw carry from the MSB.
  - overflow (1 bit): signed overflow, carry into MSB XOR carry out of MSB.
  - zero (1 bit): sum == 0.
- Not defined: these ports do not exist and no flag logic is synthesized. out/out_valid behaviour is identical in both builds.

Decomposition:
- Shared package addsub_pkg:
  - ADDSUB_W = 64
  - CLA_GROUP = 4
  - typedef word_t (logic [ADDSUB_W-1:0])
  - opcode constants OP_ADD = 1'b0 and OP_SUB = 1'b1
- One sub-module, cla_group4: inputs a[3:0], b[3:0], cin; outputs s[3:0], cout, group propagate, group generate. Instantiated WIDTH/4 times by a generate loop in adder_subtractor_64.
- Operand inversion, accumulate mux and output registers live in the top.

Test Plan:
- Reset low with in_valid=1, then release → out=0 and out_valid=0 while low; the first edge after release with a=5, b=3, sub=0 gives out=8, out_valid=1 one cycle later.
- Subtract: a=0, b=0x0000_0000_0000_0007, sub=1 → out=0xFFFF_FFFF_FFFF_FFF9. With ADDSUB_FLAGS_EN: carry_out=0, overflow=0.
- Wrap/overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → out=0x8000_0000_0000_0000. With ADDSUB_FLAGS_EN: overflow=1, zero=0.
- Accumulate chain: clr, then b=10 acc=1 sub=0, then b=4 acc=1 sub=1, then b=−3 acc=1 sub=0 on consecutive cycles → out = 10, 6, 3; out_valid high each cycle.
- Priority: in_valid=1 and clr=1 on the same edge with a=9, b=9 → out=0, out_valid=0. Next edge with in_valid=0 → out holds 0.
- Random regression: 10,000 random a, b, sub, acc vectors against a behavioural reference model, including a=b, a=0, b=min and b=max.
